// File: rtl/leaf_pkt_pkg.sv
// Shared field widths, bit offsets, packet layout and FSM encodings for the leaf stream packetizer.
// Optional retransmit support is enabled by defining PACKETIZER_RESEND_EN.
package leaf_pkt_pkg;

  localparam int unsigned PACKET_W  = 49;
  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned LEAF_W    = 5;
  localparam int unsigned PORT_W    = 4;
  localparam int unsigned ADDR_W    = 7;

  localparam int unsigned ADDR_LSB  = PAYLOAD_W;
  localparam int unsigned PORT_LSB  = ADDR_LSB + ADDR_W;
  localparam int unsigned LEAF_LSB  = PORT_LSB + PORT_W;
  localparam int unsigned VALID_BIT = LEAF_LSB + LEAF_W;

  // BFT packet, MSB to LSB
  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] payload;
  } leaf_pkt_t;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

endpackage

// File: rtl/leaf_stream_packetizer_if.sv
// User-side and BFT-side signals of the leaf stream packetizer; master drives, slave is the packetizer.
interface leaf_stream_packetizer_if
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = PACKET_W,
  parameter int unsigned PAYLOAD_BITS  = PAYLOAD_W,
  parameter int unsigned NUM_ADDR_BITS = ADDR_W
);

  logic                     ap_start;
  logic [PAYLOAD_BITS-1:0]  din_user;
  logic                     vld_user2interface;
  logic                     ack_interface2user;
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;
  logic [PACKET_BITS-1:0]   din_leaf_bft2interface;
  logic                     resend;
  logic [NUM_ADDR_BITS:0]   credit_count;

  modport master (
    output ap_start, din_user, vld_user2interface, din_leaf_bft2interface, resend,
    input  ack_interface2user, dout_leaf_interface2bft, credit_count
  );

  modport slave (
    input  ap_start, din_user, vld_user2interface, din_leaf_bft2interface, resend,
    output ack_interface2user, dout_leaf_interface2bft, credit_count
  );

endinterface

// File: rtl/leaf_credit_counter.sv
// Receiver-buffer credit tracker: one credit per sent packet, a block of credits per freespace update,
// saturating at the buffer depth and never dropping below zero.
module leaf_credit_counter #(
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send_i,
  input  logic                   update_i,
  output logic [NUM_ADDR_BITS:0] credit_o
);

  localparam int unsigned CW = NUM_ADDR_BITS + 1;
  localparam int unsigned SW = 32;
  localparam logic [SW-1:0] MAX_CREDIT = SW'(2 ** NUM_ADDR_BITS);

  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] sum_c;

  // Widened sum so a coincident send and update nets out before saturation
  always_comb begin
    sum_c = SW'(credit_q);
    if (update_i) begin
      sum_c = sum_c + SW'(FREESPACE_UPDATE_SIZE);
    end
    if (send_i && (credit_q != '0)) begin
      sum_c = sum_c - SW'(1);
    end
    credit_d = (sum_c > MAX_CREDIT) ? CW'(MAX_CREDIT) : CW'(sum_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= CW'(MAX_CREDIT);
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Wraps user words into BFT packets under credit flow control; freespace updates replenish credits.
// Define PACKETIZER_RESEND_EN to keep the last packet and re-emit it on a resend request.
module leaf_stream_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = PACKET_W,
  parameter int unsigned PAYLOAD_BITS          = PAYLOAD_W,
  parameter int unsigned NUM_LEAF_BITS         = LEAF_W,
  parameter int unsigned NUM_PORT_BITS         = PORT_W,
  parameter int unsigned NUM_ADDR_BITS         = ADDR_W,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
  parameter int unsigned DEST_LEAF             = 2,
  parameter int unsigned DEST_PORT             = 2,
  parameter int unsigned SELF_LEAF             = 1,
  parameter int unsigned SELF_CTRL_PORT        = 1
) (
  input logic                     clk,
  input logic                     reset,
  leaf_stream_packetizer_if.slave bus
);

  localparam int unsigned F_ADDR_LSB = PAYLOAD_BITS;
  localparam int unsigned F_PORT_LSB = F_ADDR_LSB + NUM_ADDR_BITS;
  localparam int unsigned F_LEAF_LSB = F_PORT_LSB + NUM_PORT_BITS;
  localparam int unsigned F_VALID    = F_LEAF_LSB + NUM_LEAF_BITS;

  localparam logic [PACKET_BITS-1:0] VALID_MASK = PACKET_BITS'(1) << F_VALID;

  // Only valid/leaf/port decide whether an incoming packet is a freespace update
  localparam logic [PACKET_BITS-1:0] UPD_MASK = VALID_MASK
    | (PACKET_BITS'({NUM_LEAF_BITS{1'b1}}) << F_LEAF_LSB)
    | (PACKET_BITS'({NUM_PORT_BITS{1'b1}}) << F_PORT_LSB);
  localparam logic [PACKET_BITS-1:0] UPD_MATCH = VALID_MASK
    | (PACKET_BITS'(NUM_LEAF_BITS'(SELF_LEAF)) << F_LEAF_LSB)
    | (PACKET_BITS'(NUM_PORT_BITS'(SELF_CTRL_PORT)) << F_PORT_LSB);

  localparam logic [PACKET_BITS-1:0] OUT_HDR = VALID_MASK
    | (PACKET_BITS'(NUM_LEAF_BITS'(DEST_LEAF)) << F_LEAF_LSB)
    | (PACKET_BITS'(NUM_PORT_BITS'(DEST_PORT)) << F_PORT_LSB);

  logic [1:0]               state_q, state_d;
  logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [PACKET_BITS-1:0]   new_pkt_c;
  logic [NUM_ADDR_BITS:0]   credit;
  logic                     ack_c;
  logic                     update_c;
  logic                     resend_active_c;

`ifdef PACKETIZER_RESEND_EN
  logic [PACKET_BITS-1:0]   last_q, last_d;

  assign resend_active_c = bus.resend;
`else
  logic unused_resend;

  assign resend_active_c = 1'b0;
  assign unused_resend   = bus.resend;
`endif

  assign update_c  = (bus.din_leaf_bft2interface & UPD_MASK) == UPD_MATCH;
  assign new_pkt_c = OUT_HDR
                   | (PACKET_BITS'(wr_addr_q) << F_ADDR_LSB)
                   | PACKET_BITS'(bus.din_user);

  leaf_credit_counter #(
    .NUM_ADDR_BITS         (NUM_ADDR_BITS),
    .FREESPACE_UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .send_i   (ack_c),
    .update_i (update_c),
    .credit_o (credit)
  );

  // Next state, handshake and next packet
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    dout_d    = '0;
`ifdef PACKETIZER_RESEND_EN
    last_d    = last_q;
`endif
    ack_c     = bus.vld_user2interface && (state_q == ST_RUN) && (credit != '0) && !resend_active_c;

    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.ap_start)      state_d = ST_IDLE;
        else if (credit == '0)  state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!bus.ap_start)      state_d = ST_IDLE;
        else if (credit != '0)  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ack_c) begin
      dout_d    = new_pkt_c;
      wr_addr_d = wr_addr_q + NUM_ADDR_BITS'(1);
`ifdef PACKETIZER_RESEND_EN
      last_d    = new_pkt_c;
    end else if (resend_active_c && last_q[F_VALID]) begin
      dout_d    = last_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      dout_q    <= dout_d;
    end
  end

`ifdef PACKETIZER_RESEND_EN
  // An empty holding register (valid=0) means nothing has been sent yet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign bus.ack_interface2user      = ack_c;
  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.credit_count            = credit;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Self-checking bench for leaf_stream_packetizer against a cycle-level behavioural model.
// Expectations follow PACKETIZER_RESEND_EN when it is defined for the build.
module tb_leaf_stream_packetizer;
  import leaf_pkt_pkg::*;

  localparam int MAXC    = 128;
  localparam int UPD     = 64;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALL = 2;
`ifdef PACKETIZER_RESEND_EN
  localparam bit RESEND_EN = 1'b1;
`else
  localparam bit RESEND_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  int                  m_state;
  int                  m_cred;
  int                  m_addr;
  bit                  m_have_last;
  logic [PACKET_W-1:0] m_dout;
  logic [PACKET_W-1:0] m_last;
  logic                exp_ack;
  logic                obs_ack;

  leaf_stream_packetizer_if bus ();

  leaf_stream_packetizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PACKET_W-1:0] make_pkt(input int addr, input logic [PAYLOAD_W-1:0] data);
    leaf_pkt_t p;
    p.valid   = 1'b1;
    p.leaf    = LEAF_W'(2);
    p.port    = PORT_W'(2);
    p.addr    = ADDR_W'(addr % MAXC);
    p.payload = data;
    return p;
  endfunction

  function automatic logic [PACKET_W-1:0] make_ctrl(input int leaf, input int port, input bit valid);
    leaf_pkt_t p;
    p.valid   = valid;
    p.leaf    = LEAF_W'(leaf);
    p.port    = PORT_W'(port);
    p.addr    = ADDR_W'($urandom);
    p.payload = $urandom;
    return p;
  endfunction

  function automatic bit is_update(input logic [PACKET_W-1:0] pkt);
    leaf_pkt_t p;
    p = pkt;
    return (p.valid === 1'b1) && (p.leaf == LEAF_W'(1)) && (p.port == PORT_W'(1));
  endfunction

  task automatic drive_idle();
    bus.ap_start               = 1'b0;
    bus.din_user               = '0;
    bus.vld_user2interface     = 1'b0;
    bus.din_leaf_bft2interface = '0;
    bus.resend                 = 1'b0;
  endtask

  task automatic model_reset();
    m_state     = M_IDLE;
    m_cred      = MAXC;
    m_addr      = 0;
    m_have_last = 1'b0;
    m_dout      = '0;
    m_last      = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock: sample ack mid-cycle, advance the model, return 1 time unit after the edge
  task automatic step();
    bit up;
    bit res_act;
    int old_cred;
    @(negedge clk);
    obs_ack  = bus.ack_interface2user;
    res_act  = RESEND_EN && (bus.resend === 1'b1);
    exp_ack  = (bus.vld_user2interface === 1'b1) && (m_state == M_RUN) && (m_cred > 0) && !res_act;
    up       = is_update(bus.din_leaf_bft2interface);
    old_cred = m_cred;
    if (exp_ack) begin
      m_dout      = make_pkt(m_addr, bus.din_user);
      m_last      = m_dout;
      m_have_last = 1'b1;
      m_addr      = (m_addr + 1) % MAXC;
    end else if (res_act && m_have_last) begin
      m_dout = m_last;
    end else begin
      m_dout = '0;
    end
    m_cred = m_cred - (exp_ack ? 1 : 0) + (up ? UPD : 0);
    if (m_cred > MAXC) m_cred = MAXC;
    case (m_state)
      M_IDLE:  if (bus.ap_start === 1'b1) m_state = M_RUN;
      M_RUN:   if (bus.ap_start !== 1'b1) m_state = M_IDLE; else if (old_cred == 0) m_state = M_STALL;
      default: if (bus.ap_start !== 1'b1) m_state = M_IDLE; else if (old_cred != 0) m_state = M_RUN;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset                  = 1'b0;
    bus.ap_start           = 1'b1;
    bus.vld_user2interface = 1'b1;
    bus.din_user           = $urandom;
    @(posedge clk);
    #2;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++; $display("FAIL reset_dout: got %h required 0", bus.dout_leaf_interface2bft);
    end
    checks++;
    if (bus.ack_interface2user !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b required 0", bus.ack_interface2user);
    end
    checks++;
    if (bus.credit_count !== 8'd128) begin
      errors++; $display("FAIL reset_credit: got %0d required 128", bus.credit_count);
    end
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [PACKET_W-1:0] want;
    bus.ap_start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.din_user           = 32'hA000_0000 + 32'(i);
      bus.vld_user2interface = 1'b1;
      step();
      want = make_pkt(i, 32'hA000_0000 + 32'(i));
      checks++;
      if (obs_ack !== 1'b1 || bus.dout_leaf_interface2bft !== want || m_dout !== want) begin
        errors++;
        $display("FAIL b2b_pkt%0d: ack=%b dout=%h required ack=1 dout=%h", i, obs_ack, bus.dout_leaf_interface2bft, want);
      end
    end
    bus.vld_user2interface = 1'b0;
    step();
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++; $display("FAIL b2b_single_valid: dout=%h required 0", bus.dout_leaf_interface2bft);
    end
    checks++;
    if (bus.credit_count !== 8'd124) begin
      errors++; $display("FAIL b2b_credit: got %0d required 124", bus.credit_count);
    end
  endtask

  task automatic test_stall_wrap();
    int acks = 0;
    apply_reset();
    bus.ap_start = 1'b1;
    step();
    bus.vld_user2interface = 1'b1;
    for (int cyc = 0; cyc < 400 && acks < MAXC; cyc++) begin
      bus.din_user = $urandom;
      step();
      if (obs_ack === 1'b1) acks++;
      checks++;
      if (obs_ack !== exp_ack || bus.dout_leaf_interface2bft !== m_dout) begin
        errors++;
        $display("FAIL fill_stream: ack=%b dout=%h required ack=%b dout=%h", obs_ack, bus.dout_leaf_interface2bft, exp_ack, m_dout);
      end
    end
    checks++;
    if (acks != MAXC) begin
      errors++; $display("FAIL fill_count: acks=%0d required %0d", acks, MAXC);
    end
    step();
    checks++;
    if (obs_ack !== 1'b0 || bus.credit_count !== 8'd0) begin
      errors++; $display("FAIL word129: ack=%b credit=%0d required ack=0 credit=0", obs_ack, bus.credit_count);
    end
    step();
    bus.din_leaf_bft2interface = make_ctrl(1, 1, 1'b1);
    step();
    bus.din_leaf_bft2interface = '0;
    checks++;
    if (obs_ack !== 1'b0 || bus.credit_count !== 8'd64) begin
      errors++; $display("FAIL stall_update: ack=%b credit=%0d required ack=0 credit=64", obs_ack, bus.credit_count);
    end
    step();
    checks++;
    if (obs_ack !== 1'b0) begin
      errors++; $display("FAIL stall_exit: ack=%b required 0", obs_ack);
    end
    step();
    checks++;
    if (obs_ack !== 1'b1 || bus.dout_leaf_interface2bft !== make_pkt(0, bus.din_user)) begin
      errors++;
      $display("FAIL wrap_pkt: ack=%b dout=%h required ack=1 dout=%h", obs_ack, bus.dout_leaf_interface2bft, make_pkt(0, bus.din_user));
    end
    bus.vld_user2interface = 1'b0;
    step();
  endtask

  task automatic test_update_coincident();
    apply_reset();
    bus.ap_start = 1'b1;
    step();
    bus.vld_user2interface = 1'b1;
    for (int i = 0; i < MAXC - 10; i++) begin
      bus.din_user = $urandom;
      step();
    end
    checks++;
    if (bus.credit_count !== 8'd10) begin
      errors++; $display("FAIL credit_at10: got %0d required 10", bus.credit_count);
    end
    bus.din_leaf_bft2interface = make_ctrl(1, 1, 1'b1);
    step();
    bus.din_leaf_bft2interface = '0;
    bus.vld_user2interface     = 1'b0;
    checks++;
    if (obs_ack !== 1'b1 || bus.credit_count !== 8'd73) begin
      errors++; $display("FAIL send_plus_update: ack=%b credit=%0d required ack=1 credit=73", obs_ack, bus.credit_count);
    end
    apply_reset();
    bus.ap_start = 1'b1;
    step();
    bus.vld_user2interface = 1'b1;
    repeat (28) step();
    bus.vld_user2interface = 1'b0;
    checks++;
    if (bus.credit_count !== 8'd100) begin
      errors++; $display("FAIL credit_at100: got %0d required 100", bus.credit_count);
    end
    for (int k = 0; k < 2; k++) begin
      bus.din_leaf_bft2interface = make_ctrl(1, 1, 1'b1);
      step();
      checks++;
      if (bus.credit_count !== 8'd128) begin
        errors++; $display("FAIL saturate%0d: got %0d required 128", k, bus.credit_count);
      end
    end
    bus.din_leaf_bft2interface = '0;
  endtask

  task automatic test_foreign_packet();
    int leafs[3] = '{1, 1, 2};
    int ports[3] = '{3, 1, 1};
    bit vlds[3]  = '{1'b1, 1'b0, 1'b1};
    apply_reset();
    bus.ap_start = 1'b1;
    step();
    bus.vld_user2interface = 1'b1;
    repeat (5) step();
    bus.vld_user2interface = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.din_leaf_bft2interface = make_ctrl(leafs[k], ports[k], vlds[k]);
      step();
      checks++;
      if (bus.credit_count !== 8'd123) begin
        errors++; $display("FAIL foreign%0d: credit=%0d required 123", k, bus.credit_count);
      end
    end
    bus.din_leaf_bft2interface = '0;
  endtask

  task automatic test_resend();
    logic [PACKET_W-1:0] first;
    logic [PACKET_W-1:0] want;
    apply_reset();
    bus.ap_start = 1'b1;
    bus.resend   = 1'b1;
    step();
    step();
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++; $display("FAIL resend_empty: dout=%h required 0", bus.dout_leaf_interface2bft);
    end
    bus.resend             = 1'b0;
    bus.vld_user2interface = 1'b1;
    bus.din_user           = 32'h1234_5678;
    step();
    bus.vld_user2interface = 1'b0;
    first = make_pkt(0, 32'h1234_5678);
    checks++;
    if (obs_ack !== 1'b1 || bus.dout_leaf_interface2bft !== first) begin
      errors++; $display("FAIL resend_orig: ack=%b dout=%h required ack=1 dout=%h", obs_ack, bus.dout_leaf_interface2bft, first);
    end
    bus.resend = 1'b1;
    step();
    bus.resend = 1'b0;
    want = RESEND_EN ? first : '0;
    checks++;
    if (bus.dout_leaf_interface2bft !== want || bus.credit_count !== 8'd127) begin
      errors++;
      $display("FAIL resend_copy: dout=%h credit=%0d required dout=%h credit=127", bus.dout_leaf_interface2bft, bus.credit_count, want);
    end
    step();
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++; $display("FAIL resend_one_cycle: dout=%h required 0", bus.dout_leaf_interface2bft);
    end
    bus.resend             = 1'b1;
    bus.vld_user2interface = 1'b1;
    bus.din_user           = 32'hCAFE_F00D;
    step();
    bus.resend             = 1'b0;
    bus.vld_user2interface = 1'b0;
    want = RESEND_EN ? first : make_pkt(1, 32'hCAFE_F00D);
    checks++;
    if (obs_ack !== !RESEND_EN || bus.dout_leaf_interface2bft !== want) begin
      errors++;
      $display("FAIL resend_blocks_ack: ack=%b dout=%h required ack=%b dout=%h", obs_ack, bus.dout_leaf_interface2bft, !RESEND_EN, want);
    end
  endtask

  task automatic test_reset_midpacket();
    apply_reset();
    bus.ap_start = 1'b1;
    step();
    bus.vld_user2interface = 1'b1;
    bus.din_user           = $urandom;
    step();
    checks++;
    if (obs_ack !== 1'b1 || bus.dout_leaf_interface2bft !== m_dout) begin
      errors++; $display("FAIL mid_send: ack=%b dout=%h required ack=1 dout=%h", obs_ack, bus.dout_leaf_interface2bft, m_dout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0 || bus.ack_interface2user !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: dout=%h ack=%b required dout=0 ack=0", bus.dout_leaf_interface2bft, bus.ack_interface2user);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    checks++;
    if (bus.credit_count !== 8'd128) begin
      errors++; $display("FAIL mid_credit: got %0d required 128", bus.credit_count);
    end
    step();
    step();
    checks++;
    if (obs_ack !== 1'b1 || bus.dout_leaf_interface2bft !== make_pkt(0, bus.din_user)) begin
      errors++;
      $display("FAIL mid_addr0: ack=%b dout=%h required ack=1 dout=%h", obs_ack, bus.dout_leaf_interface2bft, make_pkt(0, bus.din_user));
    end
    bus.vld_user2interface = 1'b0;
    step();
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.ap_start           = ($urandom_range(0, 29) != 0);
      bus.vld_user2interface = ($urandom_range(0, 9) < 8);
      bus.din_user           = $urandom;
      bus.resend             = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 149);
      if (r == 0)      bus.din_leaf_bft2interface = make_ctrl(1, 1, 1'b1);
      else if (r < 10) bus.din_leaf_bft2interface = make_ctrl($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      else             bus.din_leaf_bft2interface = '0;
      step();
      checks++;
      if (obs_ack !== exp_ack || bus.dout_leaf_interface2bft !== m_dout || bus.credit_count !== 8'(m_cred)) begin
        errors++;
        $display("FAIL random_cyc%0d: ack=%b dout=%h credit=%0d required ack=%b dout=%h credit=%0d",
                 cyc, obs_ack, bus.dout_leaf_interface2bft, bus.credit_count, exp_ack, m_dout, m_cred);
      end
    end
    drive_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_back_to_back();
    test_stall_wrap();
    test_update_coincident();
    test_foreign_packet();
    test_resend();
    test_reset_midpacket();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
